// File: rtl/eca_regs_pkg.sv
// ============================================================================
// Module      : eca_regs_pkg
// Description : Shared register map, CTRL/STATUS bit positions and CFG_KM
//               field ranges for the ECA register responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package eca_regs_pkg;

    // Register addresses
    localparam int ADDR_CTRL    = 0;
    localparam int ADDR_STATUS  = 1;
    localparam int ADDR_CFG_KM  = 2;
    localparam int ADDR_SCRATCH = 3;

    // CTRL bits (write-only pulses, register reads as 0)
    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_SW_RST_BIT = 1;

    // STATUS bits
    localparam int STATUS_BUSY_BIT     = 0;  // read-only engine busy
    localparam int STATUS_DONE_BIT     = 1;  // sticky, write-1-to-clear
    localparam int STATUS_ADDR_ERR_BIT = 2;  // sticky, write-1-to-clear

    // CFG_KM fields
    localparam int CFG_K_LSB = 0;
    localparam int CFG_K_MSB = 7;
    localparam int CFG_M_LSB = 8;
    localparam int CFG_M_MSB = 15;

endpackage : eca_regs_pkg

`default_nettype wire

// File: rtl/eca_regs_rd_resp.sv
// ============================================================================
// Module      : eca_regs_rd_resp
// Description : Read-response FSM. Captures the read value in the request
//               cycle and presents it for one cycle with a valid pulse.
//               Back-to-back requests give back-to-back responses.
//               Optional macro ECA_REGS_RD_PIPE_EN adds one output register
//               stage (latency 2, throughput unchanged).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eca_regs_rd_resp #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [DATA_W-1:0] rd_data_in,
    output logic [DATA_W-1:0] regs_rd_data,
    output logic              regs_rd_data_val
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RESP = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_next;
    logic [DATA_W-1:0] r_data;
    logic              w_val;
    logic [DATA_W-1:0] w_data;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: any request (from IDLE or RESP) yields a RESP cycle
    always_comb begin
        w_state_next = S_IDLE;
        if (rd_req) begin
            w_state_next = S_RESP;
        end
    end

    // Capture read value in the request cycle (read-before-write ordering)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else begin
            r_data <= rd_req ? rd_data_in : '0;
        end
    end

    // Outputs: data is forced to zero outside a response cycle
    always_comb begin
        w_val  = (r_state == S_RESP);
        w_data = '0;
        if (r_state == S_RESP) begin
            w_data = r_data;
        end
    end

`ifdef ECA_REGS_RD_PIPE_EN
    logic              r_pipe_val;
    logic [DATA_W-1:0] r_pipe_data;

    // Extra output stage; async reset still kills an in-flight response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_val  <= 1'b0;
            r_pipe_data <= '0;
        end else begin
            r_pipe_val  <= w_val;
            r_pipe_data <= w_data;
        end
    end

    assign regs_rd_data_val = r_pipe_val;
    assign regs_rd_data     = r_pipe_data;
`else
    assign regs_rd_data_val = w_val;
    assign regs_rd_data     = w_data;
`endif

endmodule : eca_regs_rd_resp

`default_nettype wire

// File: rtl/eca_regs_responder.sv
// ============================================================================
// Module      : eca_regs_responder
// Description : Register file at the far end of the ECA host register IF.
//               CTRL pulses, STATUS (busy / sticky done / sticky addr_err),
//               CFG_KM (frozen while engine busy), SCRATCH and generic RW regs.
//               Macro ECA_REGS_RD_PIPE_EN selects read latency 2 (else 1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eca_regs_responder
    import eca_regs_pkg::*;
#(
    parameter int                      COMMON_REG_W = 32,
    parameter int                      NUM_REGS     = 16,
    parameter logic [COMMON_REG_W-1:0] SCRATCH_RST  = '0,
    localparam int                     REGS_ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             regs_wr_req,
    input  logic [REGS_ADDR_W-1:0]           regs_wr_addr,
    input  logic [COMMON_REG_W-1:0]          regs_wr_data,
    input  logic                             regs_rd_req,
    input  logic [REGS_ADDR_W-1:0]           regs_rd_addr,
    output logic [COMMON_REG_W-1:0]          regs_rd_data,
    output logic                             regs_rd_data_val,
    input  logic                             eng_busy,
    input  logic                             eng_done,
    output logic                             ctrl_start,
    output logic                             ctrl_sw_rst,
    output logic [NUM_REGS*COMMON_REG_W-1:0] cfg_regs
);

    localparam logic [REGS_ADDR_W:0]    c_num_regs    = (REGS_ADDR_W+1)'(NUM_REGS);
    localparam logic [COMMON_REG_W-1:0] c_cfg_km_mask =
        (COMMON_REG_W'(1) << (CFG_M_MSB + 1)) - COMMON_REG_W'(1);

    logic                    w_wr_in_range;
    logic                    w_rd_in_range;
    logic                    w_wr_ctrl;
    logic                    w_wr_status;
    logic                    w_done_clr;
    logic                    w_err_clr;
    logic                    w_err_set;
    logic                    w_sticky_clr;
    logic                    r_ctrl_start;
    logic                    r_ctrl_sw_rst;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_addr_err;
    logic [COMMON_REG_W-1:0] w_image [NUM_REGS];
    logic [COMMON_REG_W-1:0] w_rd_value;

    // Write/read address decode and STATUS event terms
    always_comb begin
        w_wr_in_range = ({1'b0, regs_wr_addr} < c_num_regs);
        w_rd_in_range = ({1'b0, regs_rd_addr} < c_num_regs);
        w_wr_ctrl     = regs_wr_req && (regs_wr_addr == REGS_ADDR_W'(ADDR_CTRL));
        w_wr_status   = regs_wr_req && (regs_wr_addr == REGS_ADDR_W'(ADDR_STATUS));
        w_done_clr    = w_wr_status && regs_wr_data[STATUS_DONE_BIT];
        w_err_clr     = w_wr_status && regs_wr_data[STATUS_ADDR_ERR_BIT];
        w_sticky_clr  = w_wr_ctrl && regs_wr_data[CTRL_SW_RST_BIT];
        w_err_set     = (regs_wr_req && !w_wr_in_range) ||
                        (regs_rd_req && !w_rd_in_range);
    end

    // CTRL pulses: high exactly the cycle after the CTRL write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl_start  <= 1'b0;
            r_ctrl_sw_rst <= 1'b0;
        end else begin
            r_ctrl_start  <= w_wr_ctrl && regs_wr_data[CTRL_START_BIT];
            r_ctrl_sw_rst <= w_sticky_clr;
        end
    end

    // STATUS: busy mirror; sticky bits where a set event beats any clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_busy     <= eng_busy;
            r_done     <= eng_done  || (r_done     && !w_done_clr && !w_sticky_clr);
            r_addr_err <= w_err_set || (r_addr_err && !w_err_clr  && !w_sticky_clr);
        end
    end

    assign w_image[ADDR_CTRL] = '0;

    always_comb begin
        w_image[ADDR_STATUS]                      = '0;
        w_image[ADDR_STATUS][STATUS_BUSY_BIT]     = r_busy;
        w_image[ADDR_STATUS][STATUS_DONE_BIT]     = r_done;
        w_image[ADDR_STATUS][STATUS_ADDR_ERR_BIT] = r_addr_err;
    end

    // Storage registers: CFG_KM, SCRATCH and the generic RW registers
    generate
        for (genvar i = ADDR_CFG_KM; i < NUM_REGS; i++) begin : g_rw_reg
            localparam logic [REGS_ADDR_W-1:0]  c_idx  = REGS_ADDR_W'(i);
            localparam logic [COMMON_REG_W-1:0] c_mask =
                (i == ADDR_CFG_KM) ? c_cfg_km_mask : '1;
            localparam logic [COMMON_REG_W-1:0] c_rst  =
                (i == ADDR_SCRATCH) ? SCRATCH_RST : '0;

            logic r_unused_lock;
            logic [COMMON_REG_W-1:0] r_val;
            logic                    w_wr_en;

            // CFG_KM is locked while the engine runs
            assign r_unused_lock = (i == ADDR_CFG_KM) && eng_busy;
            assign w_wr_en = regs_wr_req && (regs_wr_addr == c_idx) && !r_unused_lock;

            // Register update on an accepted write
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_val <= c_rst;
                end else if (w_wr_en) begin
                    r_val <= regs_wr_data & c_mask;
                end
            end

            assign w_image[i] = r_val;
        end

        for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
            assign cfg_regs[i*COMMON_REG_W +: COMMON_REG_W] = w_image[i];
        end
    endgenerate

    // Read mux sampled in the request cycle; out-of-range reads return 0
    always_comb begin
        w_rd_value = '0;
        if (w_rd_in_range) begin
            w_rd_value = w_image[regs_rd_addr];
        end
    end

    eca_regs_rd_resp #(
        .DATA_W (COMMON_REG_W)
    ) u_rd_resp (
        .clk              (clk),
        .rst_n            (rst_n),
        .rd_req           (regs_rd_req),
        .rd_data_in       (w_rd_value),
        .regs_rd_data     (regs_rd_data),
        .regs_rd_data_val (regs_rd_data_val)
    );

    assign ctrl_start  = r_ctrl_start;
    assign ctrl_sw_rst = r_ctrl_sw_rst;

endmodule : eca_regs_responder

`default_nettype wire
